// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared state encodings, parity constants and parity helper for
//            the oversampling UART receiver.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_DELIVER = 3'd5
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Data is zero-extended to the widest legal word; extra zeros do not affect the XOR.
  function automatic logic parity_mismatch(input logic [8:0] data,
                                           input logic       par_bit,
                                           input logic       odd);
    return (^data) ^ par_bit ^ odd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module   : uart_rx_sync
// Purpose  : Two-flop synchroniser for the serial line plus a falling-edge
//            pulse on the synchronised signal. All flops reset to idle (1).
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_sync (
  input  logic clk_in,
  input  logic reset,
  input  logic data_in,
  output logic line_out,
  output logic fall_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = data_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign line_out = sync_q;
  assign fall_out = prev_q & ~sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx_param.sv
// ============================================================================
// Module   : uart_rx_param
// Purpose  : Parametrised oversampling UART receiver with start validation,
//            optional parity, stop check, error flags and valid/ready output.
//            Optional build macro UART_RX_MAJORITY_EN: 2-of-3 vote per sample.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 data_in,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  logic rx_line;
  logic rx_fall;
  logic sample;

  uart_rx_sync u_sync (
    .clk_in   (clk_in),
    .reset    (reset),
    .data_in  (data_in),
    .line_out (rx_line),
    .fall_out (rx_fall)
  );

`ifdef UART_RX_MAJORITY_EN
  // Vote over ticks N-1, N, N+1; the decision lands one tick late, so the
  // start point moves by one and every later point follows from it.
  localparam logic [TW-1:0] TICK_START = TW'(OVERSAMPLE / 2);

  logic [1:0] hist_q, hist_d;

  always_comb hist_d = {hist_q[0], rx_line};

  always_ff @(posedge clk_in) begin
    if (!reset) hist_q <= 2'b11;
    else        hist_q <= hist_d;
  end

  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_line) | (hist_q[0] & rx_line);
`else
  localparam logic [TW-1:0] TICK_START = TW'(OVERSAMPLE / 2 - 1);

  assign sample = rx_line;
`endif

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_cand_q, perr_cand_d;
  logic                 ferr_cand_q, ferr_cand_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    perr_cand_d = perr_cand_q;
    ferr_cand_d = ferr_cand_q;
    data_d      = data_q;
    ferr_d      = ferr_q;
    perr_d      = perr_q;
    ovr_d       = 1'b0;
    valid_d     = (valid_q && out_ready) ? 1'b0 : valid_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_fall) begin
          tick_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick_q == TICK_START) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = sample ? ST_IDLE : ST_DATA;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      ST_DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          shift_d = {sample, shift_q[DATA_BITS-1:1]};
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      ST_PARITY: begin
        if (tick_q == TICK_LAST) begin
          tick_d      = '0;
          perr_cand_d = parity_mismatch(9'(shift_q), sample, (PARITY_MODE == PARITY_ODD));
          state_d     = ST_STOP;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      ST_STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d      = '0;
          ferr_cand_d = ~sample;
          state_d     = ST_DELIVER;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      ST_DELIVER: begin
        // An unaccepted word is never overwritten; the new one is dropped.
        if (!valid_q || out_ready) begin
          data_d  = shift_q;
          ferr_d  = ferr_cand_q;
          perr_d  = (PARITY_MODE != PARITY_NONE) ? perr_cand_q : 1'b0;
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      perr_cand_q <= 1'b0;
      ferr_cand_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      perr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      perr_cand_q <= perr_cand_d;
      ferr_cand_q <= ferr_cand_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      perr_q      <= perr_d;
      ovr_q       <= ovr_d;
    end
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;

endmodule

`default_nettype wire
